// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-line prefetch front end:
// reset/enable constants, the fetch FSM state type, default sizing and
// a line-alignment helper.
package fetch_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic ENABLE    = 1'b1;
  localparam logic DISABLE   = 1'b0;

  localparam int unsigned DEF_LINE_W     = 64;
  localparam int unsigned DEF_MEM_LINES  = 69632;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  // Clear the byte-offset bits so the address points at the start of a line.
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned ofs_w);
    logic [31:0] mask;
    mask = (32'd1 << ofs_w) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/line_fifo.sv
// Synchronous FIFO holding {line address, line data} entries.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear_i       empties the FIFO; wins over push_i and pop_i
//   push_i/data_i write an entry (ignored when full without a pop)
//   pop_i         drop the head entry (ignored when empty)
//   data_o        head entry (raw storage, caller gates it)
//   count_o       number of stored entries
//   full_o/empty_o status flags
module line_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when paired with a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (rst == RstEnable || clear_i == ENABLE) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == DISABLE && clear_i == DISABLE && do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/inst_line_prefetch.sv
// Pipelined instruction-line fetch unit. Issues sequential line reads to a
// synchronous-read memory (data one cycle after the request), buffers the
// returned lines in a small FIFO and presents them over valid/ready.
// Fetching stops at an all-zero line or past the end of memory; flush_i
// redirects to an arbitrary byte address.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rst_addr_i      byte address fetched first after reset
//   flush_i         redirect request, flush_addr_i is the target
//   mem_req_o       read strobe, mem_idx_o line index (0 when idle)
//   mem_rdata_i     read data, valid the cycle after mem_req_o
//   line_valid_o    head valid; line_ready_i accepts it
//   line_o          head line, line_addr_o its aligned byte address
//   halted_o        fetch stopped, nothing buffered or in flight
module inst_line_prefetch
  import fetch_pkg::*;
#(
  parameter  int unsigned LINE_W     = DEF_LINE_W,
  parameter  int unsigned MEM_LINES  = DEF_MEM_LINES,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned OFS_W      = $clog2(LINE_W / 8),
  localparam int unsigned IDX_W      = $clog2(MEM_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rst_addr_i,
  input  logic              flush_i,
  input  logic [31:0]       flush_addr_i,
  output logic              mem_req_o,
  output logic [IDX_W-1:0]  mem_idx_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              line_valid_o,
  input  logic              line_ready_i,
  output logic [LINE_W-1:0] line_o,
  output logic [31:0]       line_addr_o,
  output logic              halted_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = 32 + LINE_W;
  localparam logic [31:0]      STEP        = 32'(LINE_W / 8);
  localparam logic [31:0]      MEM_LINES_L = 32'(MEM_LINES);
  localparam logic [CNT_W:0]   DEPTH_L     = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic [31:0]  pend_addr_q, pend_addr_d;
  logic         pend_q, pend_d;
  logic         dead_q, dead_d;

  logic             issue, push, pop;
  logic             in_range, credit_ok;
  logic [31:0]      line_num;
  logic [CNT_W:0]   inflight;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic [ENT_W-1:0] head;

  assign line_num  = fetch_addr_q >> OFS_W;
  assign in_range  = (line_num < MEM_LINES_L);
  // Credits count buffered lines plus the one in flight; a pop in the same
  // cycle does not return a credit, keeping line_valid_o off the ready path.
  assign inflight  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_q};
  assign credit_ok = (inflight < DEPTH_L);

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pend_addr_d  = pend_addr_q;
    pend_d       = 1'b0;
    dead_d       = 1'b0;
    issue        = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    if (rst == RstEnable) begin
      // Register block loads reset values; nothing issues or moves.
    end else if (flush_i) begin
      state_d      = FETCH;
      fetch_addr_d = line_align(flush_addr_i, OFS_W);
    end else begin
      pop   = line_valid_o & line_ready_i;
      issue = (state_q == FETCH) && credit_ok && in_range;
      if (issue) begin
        pend_d       = 1'b1;
        pend_addr_d  = fetch_addr_q;
        fetch_addr_d = fetch_addr_q + STEP;
      end
      if (state_q == FETCH && !in_range && !pend_q) begin
        state_d = HALT;
      end
      if (pend_q && !dead_q) begin
        if (mem_rdata_i != '0) begin
          push = ~fifo_full;
        end else begin
          // End of image: the request issued alongside this response is
          // already out, so mark it to be discarded on return.
          state_d = HALT;
          dead_d  = issue;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q      <= FETCH;
      fetch_addr_q <= line_align(rst_addr_i, OFS_W);
      pend_addr_q  <= '0;
      pend_q       <= 1'b0;
      dead_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pend_addr_q  <= pend_addr_d;
      pend_q       <= pend_d;
      dead_q       <= dead_d;
    end
  end

  line_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({pend_addr_q, mem_rdata_i}),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mem_req_o    = issue;
  assign mem_idx_o    = issue ? fetch_addr_q[OFS_W+IDX_W-1:OFS_W] : '0;
  assign line_valid_o = ~fifo_empty;
  assign line_o       = line_valid_o ? head[LINE_W-1:0] : '0;
  assign line_addr_o  = line_valid_o ? head[ENT_W-1:LINE_W] : '0;
  assign halted_o     = (state_q == HALT) & fifo_empty & ~pend_q;

endmodule
